// File: rtl/csr_file_irq_pkg.sv
// csr_file_irq_pkg: CSR addresses, op encodings, interrupt cause codes and mstatus layout shared by the CSR file.
package csr_file_irq_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  typedef enum logic [1:0] {OP_RW = 2'b00, OP_RS = 2'b01, OP_RC = 2'b10, OP_NONE = 2'b11} csr_op_e;
  localparam int CAUSE_MSI  = 3;
  localparam int CAUSE_MTI  = 7;
  localparam int CAUSE_MEI  = 11;
  localparam int CAUSE_PLAT = 16;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam logic [1:0] MSTATUS_MPP = 2'b11;
  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old, input logic [31:0] wdata);
    return op == OP_RW ? wdata : op == OP_RS ? (old | wdata) : (old & ~wdata);
  endfunction
endpackage

// File: rtl/csr_irq_arb.sv
// csr_irq_arb: synchronises interrupt lines into mip and picks the highest-priority enabled pending interrupt.
module csr_irq_arb
  import csr_file_irq_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               irq_sw,
  input  logic               irq_timer,
  input  logic               irq_ext,
  input  logic [NUM_IRQ-1:0] irq_plat,
  input  logic [31:0]        mie,
  input  logic               mie_global,
  output logic [31:0]        mip,
  output logic               irq_req,
  output logic [31:0]        irq_cause
);
  localparam int W = NUM_IRQ + 3;
  logic [W-1:0] meta, sync;
  logic [31:0] pend;
  logic [4:0] code;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= {irq_plat, irq_ext, irq_timer, irq_sw};
      sync <= meta;
    end
  end
  always_comb begin
    mip = '0;
    mip[CAUSE_MSI] = sync[0];
    mip[CAUSE_MTI] = sync[1];
    mip[CAUSE_MEI] = sync[2];
    for (int i = 0; i < NUM_IRQ; i++) mip[CAUSE_PLAT+i] = sync[3+i];
  end
  assign pend = mip & mie;
  // Later assignments override earlier ones, so the highest priority is applied last.
  always_comb begin
    code = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (pend[CAUSE_PLAT+i]) code = 5'(CAUSE_PLAT + i);
    if (pend[CAUSE_MTI]) code = 5'(CAUSE_MTI);
    if (pend[CAUSE_MSI]) code = 5'(CAUSE_MSI);
    if (pend[CAUSE_MEI]) code = 5'(CAUSE_MEI);
  end
  assign irq_req   = mie_global & |pend;
  assign irq_cause = irq_req ? {1'b1, 26'b0, code} : 32'h0;
endmodule

// File: rtl/csr_file_irq.sv
// csr_file_irq: machine-mode CSR file with interrupt arbitration and vectored traps; CSR_COUNTERS_EN adds mcycle/minstret.
module csr_file_irq
  import csr_file_irq_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter int          NUM_IRQ     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  input  logic               csr_we,
  input  logic [1:0]         csr_op,
  output logic [31:0]        csr_rdata,
  output logic               csr_illegal,
  input  logic               trap_enter,
  input  logic [31:0]        trap_pc,
  input  logic [31:0]        trap_cause,
  input  logic               mret_exec,
  input  logic               instr_retire,
  input  logic               irq_sw,
  input  logic               irq_timer,
  input  logic               irq_ext,
  input  logic [NUM_IRQ-1:0] irq_plat,
  output logic               irq_req,
  output logic [31:0]        irq_cause,
  output logic [31:0]        trap_target,
  output logic [31:0]        mepc_out
);
  localparam logic [31:0] MIE_MASK = 32'h0000_0888 | (((32'h1 << NUM_IRQ) - 32'h1) << 16);
  logic [31:0] mtvec, mepc, mcause, mscratch, mie, mip, rdata, new_val;
  logic st_mie, st_mpie, impl, wr, csr_wr;
  csr_op_e op;
`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
`endif
  assign op = csr_op_e'(csr_op);
  always_comb begin
    impl  = 1'b1;
    rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:   rdata = {19'b0, MSTATUS_MPP, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
      CSR_MIE:       rdata = mie;
      CSR_MIP:       rdata = mip;
      CSR_MTVEC:     rdata = mtvec;
      CSR_MEPC:      rdata = mepc;
      CSR_MCAUSE:    rdata = mcause;
      CSR_MSCRATCH:  rdata = mscratch;
      CSR_MHARTID:   rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    rdata = mcycle[31:0];
      CSR_MCYCLEH:   rdata = mcycle[63:32];
      CSR_MINSTRET:  rdata = minstret[31:0];
      CSR_MINSTRETH: rdata = minstret[63:32];
`endif
      default:       impl = 1'b0;
    endcase
  end
  assign csr_rdata   = rdata;
  assign wr          = csr_we && (op == OP_RW || (op != OP_NONE && |csr_wdata));
  assign csr_illegal = csr_we && (!impl || (wr && (csr_addr == CSR_MHARTID || csr_addr == CSR_MIP)));
  // Traps and MRET in the same cycle swallow the CSR write entirely.
  assign csr_wr      = wr && !csr_illegal && !trap_enter && !mret_exec;
  assign new_val     = csr_apply(op, rdata, csr_wdata);
  always_ff @(posedge clk) begin
    if (rst) begin
      mtvec    <= MTVEC_RESET;
      mepc     <= '0;
      mcause   <= '0;
      mscratch <= '0;
      mie      <= '0;
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
    end else if (trap_enter) begin
      mepc    <= trap_pc & ~32'h3;
      mcause  <= trap_cause;
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
    end else if (mret_exec) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (csr_wr) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          st_mie  <= new_val[MSTATUS_MIE];
          st_mpie <= new_val[MSTATUS_MPIE];
        end
        CSR_MIE:      mie      <= new_val & MIE_MASK;
        CSR_MTVEC:    mtvec    <= new_val & ~32'h2;
        CSR_MEPC:     mepc     <= new_val & ~32'h3;
        CSR_MCAUSE:   mcause   <= new_val;
        CSR_MSCRATCH: mscratch <= new_val;
        default: ;
      endcase
    end
  end
`ifdef CSR_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= csr_wr && csr_addr == CSR_MCYCLE    ? {mcycle[63:32], new_val}
                : csr_wr && csr_addr == CSR_MCYCLEH   ? {new_val, mcycle[31:0]}
                : mcycle + 64'd1;
      minstret <= csr_wr && csr_addr == CSR_MINSTRET  ? {minstret[63:32], new_val}
                : csr_wr && csr_addr == CSR_MINSTRETH ? {new_val, minstret[31:0]}
                : minstret + 64'(instr_retire);
    end
  end
`endif
  assign trap_target = (mtvec & ~32'h3) + ((mtvec[0] && trap_cause[31]) ? {25'b0, trap_cause[4:0], 2'b0} : 32'h0);
  assign mepc_out    = mepc;
  csr_irq_arb #(.NUM_IRQ(NUM_IRQ)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .irq_sw     (irq_sw),
    .irq_timer  (irq_timer),
    .irq_ext    (irq_ext),
    .irq_plat   (irq_plat),
    .mie        (mie),
    .mie_global (st_mie),
    .mip        (mip),
    .irq_req    (irq_req),
    .irq_cause  (irq_cause)
  );
endmodule
